// File: rtl/bsg_cgol_pkg.sv
// Shared definitions for the Game-of-Life board: controller states and the
// default run-length bound used by the board top and the bench.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    eWait = 2'd0,
    eBusy = 2'd1,
    eDone = 2'd2
  } cgol_state_e;

  localparam int max_game_length_gp = 10000;

endpackage

// File: rtl/bsg_cgol_ctrl.sv
// Run controller for the cell array: accepts a frame count, strobes the cells
// to load, enables them for exactly that many generations, then holds a done token.
module bsg_cgol_ctrl
  import bsg_cgol_pkg::*;
#(
  parameter int max_game_length_p = max_game_length_gp,
  localparam int frames_width_lp  = $clog2(max_game_length_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [frames_width_lp-1:0] frames_i,
  output logic                       ready_o,
  output logic                       update_o,
  output logic                       en_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic [frames_width_lp-1:0] frames_done_o
);

  localparam logic [frames_width_lp-1:0] max_lp = frames_width_lp'(max_game_length_p);

  cgol_state_e                r_state;
  logic [frames_width_lp-1:0] r_remaining;
  logic [frames_width_lp-1:0] r_frames_done;
  logic [frames_width_lp-1:0] w_sat;
  logic                       w_fire;

  assign w_sat  = (frames_i > max_lp) ? max_lp : frames_i;
  assign w_fire = v_i & (r_state == eWait);

  // Outputs are gated by reset so the cells see them drop without waiting for a clock.
  assign ready_o       = reset_n_i & (r_state == eWait);
  assign en_o          = reset_n_i & (r_state == eBusy);
  assign v_o           = reset_n_i & (r_state == eDone);
  assign update_o      = reset_n_i & w_fire;
  assign frames_done_o = r_frames_done;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= eWait;
      r_remaining   <= '0;
      r_frames_done <= '0;
    end else begin
      case (r_state)
        eWait: begin
          if (w_fire) begin
            r_remaining   <= w_sat;
            r_frames_done <= '0;
            r_state       <= (w_sat == '0) ? eDone : eBusy;
          end
        end
        eBusy: begin
          if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
          r_frames_done <= r_frames_done + 1'b1;
          if (r_remaining <= 1) r_state <= eDone;
        end
        eDone: begin
          if (yumi_i) r_state <= eWait;
        end
        default: r_state <= eWait;
      endcase
    end
  end

endmodule
